mem_reader: RTL and testbench
=============================

MEM_READER -- requirements
Module: mem_reader

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 262144, memory depth in 32-bit words.
REQ-002 SHALL have parameter LEN_W, default 19, width of the word-count input (covers 0..MEM_WORDS).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst read.
REQ-006 SHALL have port base  input  32  byte start address; bits [1:0] ignored.
REQ-007 SHALL have port len  input  LEN_W  number of words to read.
REQ-008 SHALL have port busy  output  1  high from accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port err  output  1  range error flag, valid with done.
REQ-011 SHALL have port we  output  1  memory write enable, tied 0.
REQ-012 SHALL have port addr  output  32  memory byte address.
REQ-013 SHALL have port fromMem  input  32  memory read data, valid one cycle after addr.
REQ-014 SHALL have ports out_valid output 1, out_ready input 1, out_data output 32, out_last output 1: word stream.

Function
REQ-015 SHALL implement FSM IDLE, CHECK, READ, DRAIN, FIN; reset state IDLE.
REQ-016 IDLE: start=1 SHALL latch base/len, go to CHECK; start in any other state SHALL be ignored.
REQ-017 CHECK: len=0 SHALL go to FIN with err=0; (base>>2)+len > MEM_WORDS SHALL go to FIN with err=1, no reads issued; else READ.
REQ-018 READ SHALL issue one read per cycle (addr += 4) while FIFO occupancy plus in-flight reads < 2; after the len-th issue go to DRAIN.
REQ-019 Read data SHALL be written into a 2-entry FIFO exactly one cycle after its addr cycle.
REQ-020 out_valid SHALL equal FIFO non-empty; out_data/out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 out_last SHALL be 1 only on the len-th word.
REQ-022 DRAIN SHALL go to FIN on handshake of the out_last word; FIN SHALL pulse done for one cycle, then IDLE.
REQ-023 First out_valid SHALL assert 2 cycles after start is sampled for a valid request; with out_ready held 1, throughput SHALL be 1 word/cycle.
REQ-024 addr SHALL hold its last value when no read is issued; no address wrap occurs (guaranteed by REQ-017).
REQ-025 err SHALL hold its value until the next accepted start.

Reset
REQ-026 rst SHALL asynchronously force: state IDLE, FIFO empty, in-flight count 0, busy=0, done=0, err=0, we=0, addr=0, out_valid=0, out_last=0, out_data=0.
REQ-027 rst asserted mid-burst SHALL abort it with no done pulse; late fromMem data SHALL be discarded.

Configuration
REQ-028 With MEM_READER_CSUM_EN defined: output csum (32 bits) SHALL equal the mod-2^32 sum of all words handshaken in the current burst; csum SHALL be cleared on accepted start and on reset; csum SHALL be valid with done.
REQ-029 Without MEM_READER_CSUM_EN: no csum port and no adder SHALL exist.

Structure
REQ-030 Shared package mem_pkg SHALL hold DATA_W=32, MEM_WORDS default, and the FSM state enum.
REQ-031 The 2-entry FIFO SHALL be sub-module mem_rd_fifo; all other logic stays in mem_reader.

Verification
REQ-032 base=0x0, len=4, mem words 0..3 = 0x11,0x22,0x33,0x44, out_ready=1 -> out_data 0x11..0x44 on consecutive cycles, first 2 cycles after start, out_last on 0x44, done 1 cycle later, err=0.
REQ-033 Same burst, out_ready toggling 1/0 each cycle -> identical word order, data stable during stalls, no loss or duplicate.
REQ-034 len=0 -> no addr activity, out_valid never 1, done pulse with err=0.
REQ-035 base=0xFFFF8 (word 262142), len=3 -> no reads, done pulse with err=1.
REQ-036 rst asserted after 2 of 8 words handshaken -> all outputs zero immediately; a new start then reads correctly from its own base.
REQ-037 MEM_READER_CSUM_EN defined, REQ-032 burst -> csum=0xAA at done.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the burst memory reader.
package mem_pkg;

    localparam int DATA_W        = 32;
    localparam int MEM_WORDS_DEF = 262144;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_READ,
        ST_DRAIN,
        ST_FIN
    } state_e;

endpackage

// File: rtl/mem_rd_fifo.sv
// Two-entry FIFO holding read words and their end-of-burst flag.
module mem_rd_fifo
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_last_i,
    input  logic              rd_en_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_last_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] data_q [2];
    logic [1:0]        last_q;
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;

    // NOTE: the two storage entries are reset so the head reads 0 out of reset;
    // state is only ever assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            last_q    <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            if (wr_en_i) begin
                data_q[wr_ptr_q] <= wr_data_i;
                last_q[wr_ptr_q] <= wr_last_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (rd_en_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, wr_en_i} - {1'b0, rd_en_i};
        end
    end

    assign valid_o   = (count_q != 2'd0);
    assign rd_data_o = data_q[rd_ptr_q];
    assign rd_last_o = last_q[rd_ptr_q] & valid_o;
    assign count_o   = count_q;

endmodule

// File: rtl/mem_reader.sv
// Burst memory reader: range-checks a request, streams words through a 2-entry FIFO.
// Define MEM_READER_CSUM_EN to add a running 32-bit checksum output (csum).
module mem_reader
    import mem_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF,
    parameter int LEN_W     = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       base,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              we,
    output logic [31:0]       addr,
    input  logic [31:0]       fromMem,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
`ifdef MEM_READER_CSUM_EN
    ,
    output logic [DATA_W-1:0] csum
`endif
);

    state_e           state_q, state_d;
    logic [29:0]      base_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [31:0]      addr_q;
    logic             err_q, err_d;
    logic             infl_q, infl_last_q;

    logic             accept, issue, pop;
    logic [31:0]      issue_addr;
    logic [1:0]       fifo_cnt;
    logic [2:0]       occ_sum;
    logic [32:0]      span;
    logic             unused_base_bits;

    assign unused_base_bits = ^base[1:0];
    assign pop     = out_valid & out_ready;
    // A word popped this cycle frees its slot in time for a read issued now.
    assign occ_sum = {1'b0, fifo_cnt} + {2'b0, infl_q} - {2'b0, pop};
    assign span    = {3'b0, base_q} + 33'(len_q);

    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        err_d      = err_q;
        accept     = 1'b0;
        issue      = 1'b0;
        issue_addr = addr_q + 32'd4;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    err_d   = 1'b0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (len_q == '0) begin
                    state_d = ST_FIN;
                end else if (span > 33'(MEM_WORDS)) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    // First read goes out here so data reaches the FIFO two cycles after start.
                    issue      = 1'b1;
                    issue_addr = {base_q, 2'b00};
                    rem_d      = len_q - LEN_W'(1);
                    state_d    = (len_q == LEN_W'(1)) ? ST_DRAIN : ST_READ;
                end
            end
            ST_READ: begin
                if (occ_sum < 3'd2) begin
                    issue = 1'b1;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && out_last) state_d = ST_FIN;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            addr_q      <= '0;
            err_q       <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            err_q       <= err_d;
            infl_q      <= issue;
            infl_last_q <= issue && (rem_d == '0);
            if (accept) begin
                base_q <= base[31:2];
                len_q  <= len;
            end
            if (issue) addr_q <= issue_addr;
        end
    end

    assign addr = issue ? issue_addr : addr_q;
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_FIN);
    assign err  = err_q;
    assign we   = 1'b0;

    mem_rd_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (infl_q),
        .wr_data_i (fromMem),
        .wr_last_i (infl_last_q),
        .rd_en_i   (pop),
        .valid_o   (out_valid),
        .rd_data_o (out_data),
        .rd_last_o (out_last),
        .count_o   (fifo_cnt)
    );

`ifdef MEM_READER_CSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= '0;
        end else if (pop) begin
            csum_q <= csum_q + out_data;
        end
    end

    assign csum = csum_q;
`endif

endmodule

// File: tb/tb_mem_reader.sv
// Scoreboard bench for mem_reader: expected words queued at request time, popped on handshake.
module tb_mem_reader;
    import mem_pkg::*;

    localparam int LEN_W = 19;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [31:0]      base;
    logic [LEN_W-1:0] len;
    logic             busy, done, err, we;
    logic [31:0]      addr;
    logic [31:0]      fromMem = '0;
    logic             out_valid, out_ready, out_last;
    logic [31:0]      out_data;
`ifdef MEM_READER_CSUM_EN
    logic [31:0]      csum;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    mem_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base      (base),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .we        (we),
        .addr      (addr),
        .fromMem   (fromMem),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
`ifdef MEM_READER_CSUM_EN
        ,
        .csum      (csum)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_word(input logic [29:0] w);
        case (w)
            30'd0:   return 32'h0000_0011;
            30'd1:   return 32'h0000_0022;
            30'd2:   return 32'h0000_0033;
            30'd3:   return 32'h0000_0044;
            default: return 32'h5A00_0000 ^ {2'b00, w};
        endcase
    endfunction

    // Synchronous memory: data for the address seen at an edge is valid the following cycle.
    always @(posedge clk) fromMem <= model_word(addr[31:2]);

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_burst(input string name, input logic [31:0] b, input int n, input int mode,
                             input logic exp_err, input bit check_lat, input bit poke_start);
        exp_t        e;
        int          cyc, first_valid, done_cyc, hs;
        bit          seen_done, stall, addr_moved;
        logic [31:0] addr0, prev_data, sum;
        logic        prev_last;
        exp_q.delete();
        sum = '0;
        if (!exp_err) begin
            for (int i = 0; i < n; i++) begin
                e.data = model_word(b[31:2] + 30'(i));
                e.last = (i == n - 1);
                exp_q.push_back(e);
                sum += e.data;
            end
        end
        @(negedge clk);
        addr0     = addr;
        base      = b;
        len       = LEN_W'(n);
        start     = 1'b1;
        out_ready = (mode == 0);
        @(negedge clk);
        start = 1'b0;
        base  = 32'hDEAD_BEE0;
        len   = '1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
        cyc = 1; first_valid = -1; done_cyc = -1; hs = 0;
        seen_done = 0; stall = 0; addr_moved = 0; prev_data = '0; prev_last = 1'b0;
        while (!seen_done && cyc < 400) begin
            if (poke_start && cyc == 3) begin
                start = 1'b1;
                base  = 32'h0000_0800;
                len   = LEN_W'(5);
            end else begin
                start = 1'b0;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = cyc[0];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (addr !== addr0) addr_moved = 1;
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (stall) begin
                    total++;
                    if ({out_data, out_last} !== {prev_data, prev_last}) begin
                        bad++;
                        $display("FAIL %s stall_stable: got %h/%b want %h/%b", name,
                                 out_data, out_last, prev_data, prev_last);
                    end
                end
            end
            stall     = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL %s extra_word: got %h want none", name, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_data, out_last} !== {e.data, e.last}) begin
                        bad++;
                        $display("FAIL %s word%0d: got %h/%b want %h/%b", name, hs,
                                 out_data, out_last, e.data, e.last);
                    end
                end
                hs++;
            end
            if (done) begin
                seen_done = 1;
                done_cyc  = cyc;
                total++;
                if (err !== exp_err) begin
                    bad++;
                    $display("FAIL %s err_at_done: got %b want %b", name, err, exp_err);
                end
                total++;
                if (exp_q.size() != 0) begin
                    bad++;
                    $display("FAIL %s words_missing: got %0d left want 0", name, exp_q.size());
                end
`ifdef MEM_READER_CSUM_EN
                total++;
                if (csum !== sum) begin
                    bad++;
                    $display("FAIL %s csum: got %h want %h", name, csum, sum);
                end
`endif
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        total++;
        if (!seen_done) begin
            bad++;
            $display("FAIL %s done_timeout: got no done want done", name);
        end
        total++;
        if ({done, busy, err} !== {2'b00, exp_err}) begin
            bad++;
            $display("FAIL %s after_done: got done=%b busy=%b err=%b want 0 0 %b", name,
                     done, busy, err, exp_err);
        end
        if (check_lat) begin
            total++;
            if (first_valid - 1 != 2) begin
                bad++;
                $display("FAIL %s latency: got %0d want 2", name, first_valid - 1);
            end
        end
        if (mode == 0 && !exp_err && n > 0) begin
            total++;
            if (done_cyc != first_valid + n) begin
                bad++;
                $display("FAIL %s throughput: got done at %0d want %0d", name, done_cyc, first_valid + n);
            end
        end
        if (n == 0 || exp_err) begin
            total++;
            if (addr_moved || first_valid >= 0) begin
                bad++;
                $display("FAIL %s no_reads: got addr_moved=%0d first_valid=%0d want 0 -1", name,
                         addr_moved, first_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base = '0; len = '0; out_ready = 1'b0;
        #3;
        total++;
        if ({busy, done, err, we, out_valid, out_last} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000000", {busy, done, err, we, out_valid, out_last});
        end
        total++;
        if ({addr, out_data} !== 64'h0) begin
            bad++;
            $display("FAIL reset_buses: got addr=%h data=%h want 0 0", addr, out_data);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_burst("basic", 32'h0, 4, 0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_stall();
        run_burst("stall", 32'h0, 4, 1, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_zero_len();
        run_burst("zero_len", 32'h10, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_range_err();
        run_burst("range_err", 32'h000F_FFF8, 3, 0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL range_err_hold: got %b want 1", err);
        end
    endtask

    task automatic test_boundary();
        run_burst("exact_fit", 32'h000F_FFF4, 3, 0, 1'b0, 1'b1, 1'b0);
        run_burst("unaligned", 32'h0000_0103, 2, 0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        run_burst("random_ready", 32'h0000_0080, 20, 2, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_burst("b2b_len1", 32'h0000_0200, 1, 0, 1'b0, 1'b1, 1'b0);
        run_burst("b2b_len2", 32'h0000_0300, 2, 0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_abort();
        exp_t e;
        int   hs = 0;
        int   cyc = 0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            e.data = model_word(30'h100 + 30'(i));
            e.last = (i == 7);
            exp_q.push_back(e);
        end
        @(negedge clk);
        base = 32'h0000_0400; len = LEN_W'(8); start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (hs < 2 && cyc < 50) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                total++;
                if (out_data !== e.data) begin
                    bad++;
                    $display("FAIL abort_word%0d: got %h want %h", hs, out_data, e.data);
                end
                hs++;
            end
            if (hs < 2) begin
                @(negedge clk);
                cyc++;
            end
        end
        total++;
        if (hs != 2) begin
            bad++;
            $display("FAIL abort_timeout: got %0d words want 2", hs);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy, done, err, we, out_valid, out_last, addr, out_data} !== 70'h0) begin
            bad++;
            $display("FAIL abort_outputs: got busy=%b done=%b valid=%b addr=%h data=%h want all 0",
                     busy, done, out_valid, addr, out_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_burst("after_abort", 32'h0000_0040, 3, 0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_range_err();
        test_boundary();
        test_random();
        test_back_to_back();
        test_abort();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
